// File: rtl/decode_if.sv
// decode_if
//   Bundles every signal that crosses the decode stage boundary:
//   - fetch side:     if_id__pc, if_id__ins, pipe_flush, data_hazard (stall back)
//   - branch stage:   mb_id__flush
//   - writeback side: wb_id__rd_we, wb_id__rd_addr, wb_id__rd_data
//   - execute side:   the id_ex__* pipeline register outputs
//   The master modport is the surrounding pipeline (or a testbench) that drives
//   the inputs; the slave modport is the decode stage itself.
interface decode_if;
    logic [31:0] if_id__pc;
    logic [31:0] if_id__ins;
    logic        pipe_flush;
    logic        mb_id__flush;
    logic        wb_id__rd_we;
    logic [4:0]  wb_id__rd_addr;
    logic [31:0] wb_id__rd_data;
    logic        data_hazard;
    logic        id_ex__valid;
    logic [31:0] id_ex__pc;
    logic [31:0] id_ex__rs1_data;
    logic [31:0] id_ex__rs2_data;
    logic [31:0] id_ex__imm;
    logic [4:0]  id_ex__rs1_addr;
    logic [4:0]  id_ex__rs2_addr;
    logic [4:0]  id_ex__rd_addr;
    logic [2:0]  id_ex__funct3;
    logic        id_ex__funct7_5;
    logic        id_ex__reg_we;
    logic        id_ex__mem_read;
    logic        id_ex__mem_write;
    logic        id_ex__branch;
    logic        id_ex__jal;
    logic        id_ex__jalr;
    logic        id_ex__alu_imm;
    logic        id_ex__lui;
    logic        id_ex__auipc;
    logic        id_ex__illegal;

    modport master (
        output if_id__pc, if_id__ins, pipe_flush, mb_id__flush,
               wb_id__rd_we, wb_id__rd_addr, wb_id__rd_data,
        input  data_hazard, id_ex__valid, id_ex__pc, id_ex__rs1_data,
               id_ex__rs2_data, id_ex__imm, id_ex__rs1_addr, id_ex__rs2_addr,
               id_ex__rd_addr, id_ex__funct3, id_ex__funct7_5, id_ex__reg_we,
               id_ex__mem_read, id_ex__mem_write, id_ex__branch, id_ex__jal,
               id_ex__jalr, id_ex__alu_imm, id_ex__lui, id_ex__auipc,
               id_ex__illegal
    );

    modport slave (
        input  if_id__pc, if_id__ins, pipe_flush, mb_id__flush,
               wb_id__rd_we, wb_id__rd_addr, wb_id__rd_data,
        output data_hazard, id_ex__valid, id_ex__pc, id_ex__rs1_data,
               id_ex__rs2_data, id_ex__imm, id_ex__rs1_addr, id_ex__rs2_addr,
               id_ex__rd_addr, id_ex__funct3, id_ex__funct7_5, id_ex__reg_we,
               id_ex__mem_read, id_ex__mem_write, id_ex__branch, id_ex__jal,
               id_ex__jalr, id_ex__alu_imm, id_ex__lui, id_ex__auipc,
               id_ex__illegal
    );
endinterface

// File: rtl/decode.sv
// decode
//   RV32I instruction decode stage. Reads operands from the internal 32x32
//   register file (with write-through bypass from writeback), builds the
//   immediate and control word, and registers the result into id_ex__*.
//   Raises data_hazard for a load-use dependency and inserts bubbles on
//   pipe_flush / mb_id__flush / data_hazard.
// Ports:
//   clk  - pipeline clock, rising edge
//   rst  - synchronous active-high reset (clears id_ex and the register file)
//   bus  - decode_if.slave: if_id__*, flushes, wb_id__* write port, id_ex__*
module decode (
    input logic      clk,
    input logic      rst,
    decode_if.slave  bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic        reg_we;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        alu_imm;
        logic        lui;
        logic        auipc;
        logic        illegal;
    } id_ex_t;

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic        rs1_used, rs2_used, reg_we_cls, bubble;
    logic [31:0] regs [32];
    id_ex_t      dec, id_ex_q;

    assign ins    = bus.if_id__ins;
    assign opcode = ins[6:0];
    assign rd     = ins[11:7];
    assign rs1    = ins[19:15];
    assign rs2    = ins[24:20];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    // Register file; x0 is never written and always reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (bus.wb_id__rd_we && bus.wb_id__rd_addr != 5'd0) begin
            regs[bus.wb_id__rd_addr] <= bus.wb_id__rd_data;
        end
    end

    // Write-through bypass so a value being written back this cycle is seen
    // by the instruction decoded in the same cycle.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0)
            rs1_val = (bus.wb_id__rd_we && bus.wb_id__rd_addr == rs1) ? bus.wb_id__rd_data : regs[rs1];
        if (rs2 != 5'd0)
            rs2_val = (bus.wb_id__rd_we && bus.wb_id__rd_addr == rs2) ? bus.wb_id__rd_data : regs[rs2];
    end

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = bus.if_id__pc;
        dec.rs1_data = rs1_val;
        dec.rs2_data = rs2_val;
        dec.rs1_addr = rs1;
        dec.rs2_addr = rs2;
        dec.rd_addr  = rd;
        dec.funct3   = ins[14:12];
        dec.funct7_5 = ins[30];
        rs1_used     = 1'b1;
        rs2_used     = 1'b0;
        reg_we_cls   = 1'b0;
        case (opcode)
            OPC_LUI:    begin dec.lui = 1'b1;   dec.imm = imm_u; reg_we_cls = 1'b1; rs1_used = 1'b0; end
            OPC_AUIPC:  begin dec.auipc = 1'b1; dec.imm = imm_u; reg_we_cls = 1'b1; rs1_used = 1'b0; end
            OPC_JAL:    begin dec.jal = 1'b1;   dec.imm = imm_j; reg_we_cls = 1'b1; rs1_used = 1'b0; end
            OPC_JALR:   begin dec.jalr = 1'b1;  dec.imm = imm_i; reg_we_cls = 1'b1; dec.alu_imm = 1'b1; end
            OPC_BRANCH: begin dec.branch = 1'b1; dec.imm = imm_b; rs2_used = 1'b1; end
            OPC_LOAD:   begin dec.mem_read = 1'b1; dec.imm = imm_i; reg_we_cls = 1'b1; dec.alu_imm = 1'b1; end
            OPC_STORE:  begin dec.mem_write = 1'b1; dec.imm = imm_s; dec.alu_imm = 1'b1; rs2_used = 1'b1; end
            OPC_OPIMM:  begin dec.imm = imm_i; reg_we_cls = 1'b1; dec.alu_imm = 1'b1; end
            OPC_OP:     begin reg_we_cls = 1'b1; rs2_used = 1'b1; end
            default:    dec.illegal = 1'b1;
        endcase
        dec.reg_we = reg_we_cls && (rd != 5'd0);
    end

    // Load-use stall; suppressed on either flush so fetch can take the redirect.
    assign bus.data_hazard = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd_addr != 5'd0)
                           && ((rs1_used && id_ex_q.rd_addr == rs1) || (rs2_used && id_ex_q.rd_addr == rs2))
                           && !bus.pipe_flush && !bus.mb_id__flush;

    assign bubble = bus.mb_id__flush || bus.pipe_flush || bus.data_hazard;

    always_ff @(posedge clk) begin
        if (rst || bubble) id_ex_q <= '0;
        else               id_ex_q <= dec;
    end

    assign bus.id_ex__valid     = id_ex_q.valid;
    assign bus.id_ex__pc        = id_ex_q.pc;
    assign bus.id_ex__rs1_data  = id_ex_q.rs1_data;
    assign bus.id_ex__rs2_data  = id_ex_q.rs2_data;
    assign bus.id_ex__imm       = id_ex_q.imm;
    assign bus.id_ex__rs1_addr  = id_ex_q.rs1_addr;
    assign bus.id_ex__rs2_addr  = id_ex_q.rs2_addr;
    assign bus.id_ex__rd_addr   = id_ex_q.rd_addr;
    assign bus.id_ex__funct3    = id_ex_q.funct3;
    assign bus.id_ex__funct7_5  = id_ex_q.funct7_5;
    assign bus.id_ex__reg_we    = id_ex_q.reg_we;
    assign bus.id_ex__mem_read  = id_ex_q.mem_read;
    assign bus.id_ex__mem_write = id_ex_q.mem_write;
    assign bus.id_ex__branch    = id_ex_q.branch;
    assign bus.id_ex__jal       = id_ex_q.jal;
    assign bus.id_ex__jalr      = id_ex_q.jalr;
    assign bus.id_ex__alu_imm   = id_ex_q.alu_imm;
    assign bus.id_ex__lui       = id_ex_q.lui;
    assign bus.id_ex__auipc     = id_ex_q.auipc;
    assign bus.id_ex__illegal   = id_ex_q.illegal;
endmodule

// File: doc/decode.md
# decode

Instruction decode stage of the five-stage RV32I pipeline; receiving end of the fetch stage's `if_id__` interface. Each cycle it consumes the fetched instruction and its PC, reads operands from the internal 32x32 register file, builds the immediate and control word, and registers the result into the `id_ex__` pipeline register. It also generates the load-use `data_hazard` stall back to fetch, and squashes wrong-path instructions on `pipe_flush` from fetch and `mb_id__flush` from the branch stage.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_id__pc`  in  32  PC of the instruction on `if_id__ins`.
- `if_id__ins`  in  32  fetched instruction; held stable by fetch while `data_hazard`=1.
- `pipe_flush`  in  1  fetch flag; `if_id__ins` is wrong-path this cycle.
- `mb_id__flush`  in  1  branch stage resolved a taken jump this cycle.
- `wb_id__rd_we`, `wb_id__rd_addr[4:0]`, `wb_id__rd_data[31:0]`  in  register file write port.
- `data_hazard`  out  1  combinational stall request to fetch.
- `id_ex__valid`  out  1  registered; 0 = bubble.
- `id_ex__pc`, `id_ex__rs1_data`, `id_ex__rs2_data`, `id_ex__imm`  out  32 each.
- `id_ex__rs1_addr`, `id_ex__rs2_addr`, `id_ex__rd_addr`  out  5 each.
- `id_ex__funct3`  out  3;  `id_ex__funct7_5`  out  1  (ins[30]).
- `id_ex__reg_we`, `id_ex__mem_read`, `id_ex__mem_write`, `id_ex__branch`, `id_ex__jal`, `id_ex__jalr`, `id_ex__alu_imm`, `id_ex__lui`, `id_ex__auipc`, `id_ex__illegal`  out  1 each.

## Operation
- Decode classes by opcode[6:0]: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Any other opcode: `illegal`=1, all other control bits 0, `valid`=1.
- Immediates, sign-extended from ins[31]: I {ins[31:20]}; S {ins[31:25],ins[11:7]}; B {ins[31],ins[7],ins[30:25],ins[11:8],0}; U {ins[31:12],12'b0}; J {ins[31],ins[19:12],ins[20],ins[30:21],0}. OP and illegal: imm=0.
- `reg_we`=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, except `reg_we`=0 when rd=0. `alu_imm`=1 for LOAD, STORE, OP-IMM, JALR.
- rs1 is "used" by all classes except LUI, AUIPC, JAL; rs2 is used by OP, STORE, BRANCH only.
- Register file: x0 reads 0, writes to x0 ignored. Write-through bypass: if `wb_id__rd_we` and `wb_id__rd_addr`=rsN≠0, rsN_data = `wb_id__rd_data` in the same cycle.
- Load-use hazard: `data_hazard` = `id_ex__valid` & `id_ex__mem_read` & rd≠0 & ((rs1 used & rd=rs1) | (rs2 used & rd=rs2)) & !`pipe_flush` & !`mb_id__flush`.
- Next `id_ex__` load, priority order: `rst` -> all zero; `mb_id__flush` | `pipe_flush` | `data_hazard` -> bubble (valid and every control bit 0, data fields don't-care but driven 0); else decoded instruction with `valid`=1.

## Timing
- Reset: every `id_ex__` output 0, register file all 0; `data_hazard`=0 the cycle after reset since `id_ex__valid`=0.
- Latency: instruction presented on `if_id__` in cycle N appears on `id_ex__` after edge N+1 (one cycle).
- Load-use stall is exactly one cycle: bubble inserted, stalled instruction held by fetch, issued next cycle against a non-load bubble.
- `data_hazard` must be 0 whenever either flush input is 1; otherwise fetch would drop the jump redirect.
- Flush and writeback in the same cycle: writeback still commits.
- Reset asserted mid-stall: next cycle `id_ex__valid`=0, `data_hazard`=0.

## Test plan
- Reset, then ins 0x00500093 (addi x1,x0,5) at pc 0x0 -> next cycle valid=1, rd=1, imm=5, reg_we=1, alu_imm=1, rs1_data=0.
- WB writes x2=0xDEADBEEF same cycle as add x3,x2,x2 in ID -> rs1_data=rs2_data=0xDEADBEEF (bypass).
- lw x5,0(x1) then add x6,x5,x0 -> data_hazard=1 one cycle, bubble in id_ex, add issues the following cycle; lw x0 then use of x0 -> no stall.
- beq with ins 0xFE000EE3 -> imm=0xFFFFFFFC, branch=1, reg_we=0.
- Load-use hazard pending while mb_id__flush=1 -> data_hazard=0, id_ex bubble; pipe_flush=1 alone -> bubble, no stall.
- Opcode 0x7F -> illegal=1, valid=1, all other control 0; lui x0,1 -> reg_we=0.
